// File: rtl/sms4_ck_stream_pkg.sv
// rtl/sms4_ck_stream_pkg.sv - shared constants, state type and helpers for the SMS4 CK stream
package sms4_ck_stream_pkg;

  localparam int SMS4_ROUNDS   = 32;
  localparam int SMS4_CK_MULT  = 7;
  localparam int SMS4_CK_BYTES = 4;
  localparam int SMS4_IDX_W    = 5;

  localparam logic SMS4_DIR_FWD = 1'b0;
  localparam logic SMS4_DIR_REV = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ck_state_e;

  // Elaboration-time reduction of an integer expression to a byte
  function automatic logic [7:0] mod256(input int v);
    return v[7:0];
  endfunction

endpackage

// File: rtl/sms4_ck_lane.sv
// rtl/sms4_ck_lane.sv - one byte lane of CK: base plus a folded per-lane offset
module sms4_ck_lane
  import sms4_ck_stream_pkg::*;
#(
  parameter int LANE = 0,
  parameter int MULT = SMS4_CK_MULT
) (
  input  logic [7:0] base,
  output logic [7:0] ck_byte
);

  localparam logic [7:0] OFFSET = mod256(LANE * MULT);

  assign ck_byte = base + OFFSET;

endmodule

// File: rtl/sms4_ck_stream.sv
// rtl/sms4_ck_stream.sv - streams SMS4 key-schedule constants CK_i forward or reverse
module sms4_ck_stream
  import sms4_ck_stream_pkg::*;
#(
  parameter int ROUNDS = SMS4_ROUNDS,
  parameter int BYTES  = SMS4_CK_BYTES,
  parameter int MULT   = SMS4_CK_MULT,
  parameter int IDX_W  = SMS4_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic               abort,
  output logic [8*BYTES-1:0] ck,
  output logic [IDX_W-1:0]   ck_idx,
  output logic               ck_valid,
  input  logic               ck_ready,
  output logic               ck_last,
  output logic               busy
);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [7:0]       BASE_STEP = mod256(BYTES * MULT);
  localparam logic [7:0]       BASE_LAST = mod256(BYTES * MULT * (ROUNDS - 1));

  ck_state_e          state_q, state_d;
  logic               dir_q, dir_d;
  logic [IDX_W-1:0]   idx_d;
  logic [7:0]         base_q, base_d;
  logic               last_d;
  logic [8*BYTES-1:0] ck_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = ck_idx;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          dir_d   = dir;
          if (dir == SMS4_DIR_REV) begin
            idx_d  = IDX_LAST;
            base_d = BASE_LAST;
          end else begin
            idx_d  = '0;
            base_d = '0;
          end
        end
      end
      ST_RUN: begin
        // ck_valid is always high in RUN, so ck_ready alone marks a handshake
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ck_ready) begin
          if (ck_last) begin
            state_d = ST_IDLE;
          end else if (dir_q == SMS4_DIR_REV) begin
            idx_d  = ck_idx - IDX_ONE;
            base_d = base_q - BASE_STEP;
          end else begin
            idx_d  = ck_idx + IDX_ONE;
            base_d = base_q + BASE_STEP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    last_d = (state_d == ST_RUN) &&
             (((dir_d == SMS4_DIR_FWD) && (idx_d == IDX_LAST)) ||
              ((dir_d == SMS4_DIR_REV) && (idx_d == '0)));
  end

  // Lanes see the next base so ck lands in the same register stage as ck_idx
  for (genvar j = 0; j < BYTES; j++) begin : g_lane
    sms4_ck_lane #(
      .LANE (j),
      .MULT (MULT)
    ) u_lane (
      .base    (base_d),
      .ck_byte (ck_d[8*(BYTES-1-j) +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= SMS4_DIR_FWD;
      base_q   <= '0;
      ck_idx   <= '0;
      ck       <= '0;
      ck_valid <= 1'b0;
      ck_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      base_q   <= base_d;
      ck_idx   <= idx_d;
      ck       <= ck_d;
      ck_valid <= (state_d == ST_RUN);
      ck_last  <= last_d;
      busy     <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_sms4_ck_stream.sv
// tb/tb_sms4_ck_stream.sv - self-checking bench for sms4_ck_stream
module tb_sms4_ck_stream;

  localparam int R  = 32;
  localparam int B  = 4;
  localparam int R8 = 8;
  localparam int B8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, dir = 1'b0, abort = 1'b0, ck_ready = 1'b0;
  logic [8*B-1:0] ck;
  logic [4:0]     ck_idx;
  logic           ck_valid, ck_last, busy;

  logic start8 = 1'b0, dir8 = 1'b0, abort8 = 1'b0, ready8 = 1'b0;
  logic [8*B8-1:0] ck8;
  logic [2:0]      idx8;
  logic            valid8, last8, busy8;

  always #5 clk = ~clk;

  sms4_ck_stream #(.ROUNDS(R), .BYTES(B), .MULT(7), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .ck(ck), .ck_idx(ck_idx), .ck_valid(ck_valid), .ck_ready(ck_ready),
    .ck_last(ck_last), .busy(busy)
  );

  sms4_ck_stream #(.ROUNDS(R8), .BYTES(B8), .MULT(7), .IDX_W(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dir(dir8), .abort(abort8),
    .ck(ck8), .ck_idx(idx8), .ck_valid(valid8), .ck_ready(ready8),
    .ck_last(last8), .busy(busy8)
  );

  typedef struct {
    int          idx;
    logic [31:0] ck;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] cap[R];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_c0 = 64'h00070E151C232A31;
  logic [7:0]  exp_c7 = 8'h88;

  function automatic logic [63:0] ref_ck(input int i, input int nb);
    logic [63:0] r = '0;
    for (int j = 0; j < nb; j++) r = {r[55:0], 8'(((nb * i + j) * 7) % 256)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int target);
    int cyc = 0;
    while (int'(ck_idx) != target && cyc < 100) begin
      step();
      cyc++;
    end
    chk("wait_idx", 64'(ck_idx), 64'(target));
  endtask

  task automatic run_seq(input bit d, input int pct, input bit capture);
    int exp_idx, got, cyc;
    start = 1'b1; dir = d; ck_ready = 1'b0;
    step();
    start = 1'b0;
    exp_idx = d ? R - 1 : 0;
    got = 0;
    cyc = 0;
    while (got < R && cyc < 2000) begin
      ck_ready = ($urandom_range(0, 99) < pct);
      chk("seq_valid", 64'(ck_valid), 64'd1);
      chk("seq_busy", 64'(busy), 64'd1);
      chk("seq_idx", 64'(ck_idx), 64'(exp_idx));
      chk("seq_ck", 64'(ck), ref_ck(exp_idx, B));
      chk("seq_last", 64'(ck_last), 64'(d ? (exp_idx == 0) : (exp_idx == R - 1)));
      if (capture) cap[exp_idx] = ck;
      if (ck_ready) begin
        got++;
        exp_idx += d ? -1 : 1;
      end
      step();
      cyc++;
    end
    chk("seq_count", 64'(got), 64'(R));
    ck_ready = 1'b0;
    chk("seq_end_valid", 64'(ck_valid), 64'd0);
    chk("seq_end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    tbl[0] = '{0,  32'h00070E15};
    tbl[1] = '{1,  32'h1C232A31};
    tbl[2] = '{2,  32'h383F464D};
    tbl[3] = '{5,  32'h8C939AA1};
    tbl[4] = '{30, 32'h484F565D};
    tbl[5] = '{31, 32'h646B7279};

    step();
    step();
    chk("rst_ck", 64'(ck), 64'd0);
    chk("rst_idx", 64'(ck_idx), 64'd0);
    chk("rst_valid", 64'(ck_valid), 64'd0);
    chk("rst_last", 64'(ck_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid8", 64'(valid8), 64'd0);
    rst = 1'b0;
    step();

    run_seq(1'b0, 100, 1'b1);
    for (int k = 0; k < 6; k++) chk("tbl_ck", 64'(cap[tbl[k].idx]), 64'(tbl[k].ck));

    run_seq(1'b1, 100, 1'b0);
    for (int k = 0; k < 4; k++) run_seq(1'($urandom_range(0, 1)), 55, 1'b0);

    // ready held low mid-stream
    start = 1'b1; dir = 1'b0; ck_ready = 1'b1;
    step();
    start = 1'b0;
    wait_idx(5);
    ck_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ck", 64'(ck), 64'h8C939AA1);
      chk("stall_idx", 64'(ck_idx), 64'd5);
      chk("stall_valid", 64'(ck_valid), 64'd1);
    end
    ck_ready = 1'b1;
    step();
    chk("resume_idx", 64'(ck_idx), 64'd6);
    chk("resume_ck", 64'(ck), ref_ck(6, B));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 64'(ck_valid), 64'd0);

    // abort coinciding with a handshake
    start = 1'b1; ck_ready = 1'b1;
    step();
    start = 1'b0;
    wait_idx(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_hs_valid", 64'(ck_valid), 64'd0);
    chk("abort_hs_busy", 64'(busy), 64'd0);
    chk("abort_hs_last", 64'(ck_last), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_idx", 64'(ck_idx), 64'd0);
    chk("restart_ck", 64'(ck), 64'h00070E15);
    chk("restart_valid", 64'(ck_valid), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_valid", 64'(ck_valid), 64'd0);
    chk("start_abort_busy", 64'(busy), 64'd0);

    // start ignored in RUN, then reset mid-sequence
    start = 1'b1; ck_ready = 1'b1;
    step();
    start = 1'b0;
    wait_idx(17);
    ck_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("run_start_idx", 64'(ck_idx), 64'd17);
    chk("run_start_valid", 64'(ck_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ck", 64'(ck), 64'd0);
    chk("midrst_idx", 64'(ck_idx), 64'd0);
    chk("midrst_valid", 64'(ck_valid), 64'd0);
    chk("midrst_last", 64'(ck_last), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    // start during the final handshake is not honoured
    start = 1'b1; ck_ready = 1'b1;
    step();
    start = 1'b0;
    wait_idx(31);
    chk("b2b_last", 64'(ck_last), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_valid0", 64'(ck_valid), 64'd0);
    step();
    chk("b2b_valid1", 64'(ck_valid), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd0);
    ck_ready = 1'b0;

    // 8-round, 8-byte instance
    start8 = 1'b1; ready8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 0; k < R8; k++) begin
      chk("w8_valid", 64'(valid8), 64'd1);
      chk("w8_idx", 64'(idx8), 64'(k));
      chk("w8_ck", ck8, ref_ck(k, B8));
      chk("w8_last", 64'(last8), 64'(k == R8 - 1));
      if (k == 0) chk("w8_ck0", ck8, exp_c0);
      if (k == R8 - 1) chk("w8_ck7_msb", 64'(ck8[63:56]), 64'(exp_c7));
      step();
    end
    chk("w8_end_valid", 64'(valid8), 64'd0);
    ready8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
